// File: rtl/board_led_sequencer.sv
// board_led_sequencer
//   Turns the five raw board push-buttons into debounced one-shot commands
//   and runs a mode FSM that sequences the 8 board LEDs.
//
// Ports
//   clk       system clock, the only clock
//   rst       synchronous, active-high reset
//   switches  slide switch levels, loaded into leds on a centre press
//   btn_up    raw button: count up / pause toggle
//   btn_dwn   raw button: count down / pause toggle
//   btn_lft   raw button: rotate left / pause toggle
//   btn_rt    raw button: rotate right / pause toggle
//   btn_ctr   raw button: load switches and hold
//   leds      LED drive (registered)
//   mode      current FSM state (registered)
//   tick      one-cycle step strobe
//
// State table
//   HOLD   | leds frozen, prescaler held at 0
//   CNT_UP | leds increment on every tick
//   CNT_DN | leds decrement on every tick
//   ROT_L  | leds rotate left on every tick
//   ROT_R  | leds rotate right on every tick
module board_led_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TICK_CYCLES     = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] switches,
   input  logic       btn_up,
   input  logic       btn_dwn,
   input  logic       btn_lft,
   input  logic       btn_rt,
   input  logic       btn_ctr,
   output logic [7:0] leds,
   output logic [2:0] mode,
   output logic       tick
);

   localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TK_LAST = TW'(TICK_CYCLES - 1);

   typedef enum logic [2:0] {
      HOLD   = 3'd0,
      CNT_UP = 3'd1,
      CNT_DN = 3'd2,
      ROT_L  = 3'd3,
      ROT_R  = 3'd4
   } mode_t;

   // bit order doubles as priority order: bit 0 (up) wins
   logic [4:0]    btn_raw;
   logic [4:0]    sync1;
   logic [4:0]    sync2;
   logic [4:0]    db_lvl;
   logic [4:0]    db_prev;
   logic [4:0]    press;
   logic [DW-1:0] db_cnt [5];

   mode_t         state;
   logic [7:0]    led_q;
   logic [TW-1:0] presc;

   logic          cmd_valid;
   logic          cmd_ctr;
   mode_t         cmd_target;
   logic          step;

   assign btn_raw = {btn_ctr, btn_rt, btn_lft, btn_dwn, btn_up};

   // Synchroniser, debounce and press detect. The synchroniser is reset too,
   // so a button held through reset is seen rising from 0 afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= '0;
         sync2   <= '0;
         db_lvl  <= '0;
         db_prev <= '0;
         press   <= '0;
         for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
      end else begin
         sync1   <= btn_raw;
         sync2   <= sync1;
         db_prev <= db_lvl;
         press   <= db_lvl & ~db_prev;
         for (int i = 0; i < 5; i++) begin
            if (sync2[i] == db_lvl[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_lvl[i] <= ~db_lvl[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      cmd_valid  = 1'b1;
      cmd_ctr    = 1'b0;
      cmd_target = HOLD;
      if (press[0])      cmd_target = CNT_UP;
      else if (press[1]) cmd_target = CNT_DN;
      else if (press[2]) cmd_target = ROT_L;
      else if (press[3]) cmd_target = ROT_R;
      else if (press[4]) cmd_ctr    = 1'b1;
      else               cmd_valid  = 1'b0;
   end

   assign step = (state != HOLD) && (presc == TK_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HOLD;
         led_q <= '0;
         presc <= '0;
      end else if (cmd_valid) begin
         // a command always restarts the step period and suppresses any step
         presc <= '0;
         if (cmd_ctr) begin
            led_q <= switches;
            state <= HOLD;
         end else begin
            state <= (state == cmd_target) ? HOLD : cmd_target;
         end
      end else if (state == HOLD) begin
         presc <= '0;
      end else if (step) begin
         presc <= '0;
         case (state)
            CNT_UP:  led_q <= led_q + 8'd1;
            CNT_DN:  led_q <= led_q - 8'd1;
            ROT_L:   led_q <= {led_q[6:0], led_q[7]};
            ROT_R:   led_q <= {led_q[0], led_q[7:1]};
            default: led_q <= led_q;
         endcase
      end else begin
         presc <= presc + 1'b1;
      end
   end

   assign leds = led_q;
   assign mode = state;
   assign tick = step;

endmodule
